sram_responder: RTL and testbench
=================================

# sram_responder

Synthesizable responder for the external 16-bit asynchronous SRAM pin interface (CE, OE, WE, UB, LB, ADDR, Data). It sits on the far side of the SRAM pins and replaces the physical chip with on-chip block RAM, for simulation and on-FPGA bring-up of the rasterizer's SRAM controller. Pins are sampled on each clock edge, writes commit when the write cycle ends, and read data is driven back with a fixed, configurable latency.

## Interface
- MEM_AW, 12: backing-store address width. Depth is 2^MEM_AW words. ADDR[19:MEM_AW] is ignored, so addresses alias.
- READ_LATENCY, 1: clock edges from a stable read address being sampled to Data being driven. Legal range 1..4.
- clock_100  in  1  system clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- CE  in  1  chip enable, active-low
- OE  in  1  output enable, active-low
- WE  in  1  write enable, active-low
- UB  in  1  upper byte lane enable, active-low, covers Data[15:8]
- LB  in  1  lower byte lane enable, active-low, covers Data[7:0]
- ADDR  in  20  word address
- Data  inout  16  bidirectional data bus
- wr_count  out  16  committed writes, wraps
- rd_count  out  16  completed read drives, wraps
- violation  out  1  sticky protocol-violation flag

## Operation
- States:
  - IDLE
  - WRITE_HOLD
  - READ_WAIT
  - READ_DRIVE
- Pin decode:
  - Write request = !CE & !WE.
  - Read request = !CE & WE & !OE.
- IDLE transitions:
  - Write request: capture addr, data and lanes, then go to WRITE_HOLD.
  - Read request: latch addr, load latency counter with READ_LATENCY-1, then go to READ_WAIT.
- WRITE_HOLD:
  - Each cycle with WE low and ADDR unchanged: recapture data and lanes (last value wins).
  - WE high or CE high: commit the captured word to memory (enabled lanes only), increment wr_count, then evaluate the same-cycle pins exactly as IDLE would.
  - ADDR changes while WE is low: commit the old capture, capture the new one, stay in WRITE_HOLD, set violation.
- READ_WAIT:
  - Counter at 0: register mem[addr] and go to READ_DRIVE.
  - ADDR change: reload the counter.
  - Read request dropped: return to IDLE or WRITE_HOLD per decode.
- READ_DRIVE:
  - Drive the registered word on enabled lanes; disabled lanes are Z. Increment rd_count on entry.
  - ADDR change: reload the counter and go to READ_WAIT, with Data Z meanwhile.
  - CE, OE or WE deasserted: Data Z, then decode as IDLE.
- Read-after-write forwarding: if a read samples the address committed on the same edge, the returned data is the committed word.
- Bus contention: OE low together with WE low is a write and Data is never driven. If Data is being driven and OE is seen low with WE low, set violation.
- UB and LB both high during a write: commit nothing and do not increment wr_count.
- Memory contents are not reset. In simulation they are initialised to 0.

## Timing
- Reset values: state IDLE, Data Z, wr_count 0, rd_count 0, violation 0, capture registers 0. Reset asserted mid-write discards the pending capture with no commit.
- Write commit happens on the first edge that samples WE high or CE high after WRITE_HOLD was entered.
- Read with READ_LATENCY=1:
  - ADDR is presented in cycle N and sampled at the end of N.
  - Data is valid for all of cycle N+1.
  - This matches the two-cycle read slot.
- Data output enable is a register. It is never combinational from the pins.
- Counters wrap 0xFFFF to 0x0000.

## Configuration
- SRAM_RESPONDER_TIMING_CHECK_EN
  - Defined: violation logic is present.
  - Undefined: violation is tied to 0 and the check logic is removed, while commit behaviour stays identical.

## Structure
- Shared package sram_pkg holds:
  - state enum sram_resp_state_t
  - SRAM_AW=20
  - SRAM_DW=16
  - lane-mask typedef sram_lanes_t
- The controller side already uses SRAM_AW and SRAM_DW.
- One sub-module: sram_resp_mem, a byte-enable, single-port synchronous RAM of 2^MEM_AW x 16 with write-first forwarding.

## Test plan
- Write then read back:
  - Stimulus: write 0xBEEF to 0x00012 for 2 cycles, then a read of 0x00012.
  - Required: Data=0xBEEF in the cycle after the address is sampled, wr_count=1, rd_count=1.
- Byte lanes:
  - Stimulus: write 0x1234 to 0x00005 with UB=1, LB=0, over a prior 0xFFFF.
  - Required: readback 0xFF34. A read with LB=1 drives Data[7:0]=Z.
- Forwarding:
  - Stimulus: write 0xA5A5 to 0x00100 ending on the same edge that samples a read of 0x00100.
  - Required: Data=0xA5A5, not the stale value.
- Address change during write:
  - Stimulus: WE low at 0x00001 with 0x1111, then at 0x00002 with 0x2222.
  - Required: both words committed, violation=1 with SRAM_RESPONDER_TIMING_CHECK_EN, and 0 without it.
- Latency and alias:
  - Stimulus: READ_LATENCY=3, MEM_AW=12, read 0x01003 after writing 0x00003 with 0x7777.
  - Required: Data Z for 2 cycles, then 0x7777.
- Reset mid-write:
  - Stimulus: assert reset_n low during WRITE_HOLD at 0x00009 with 0xDEAD.
  - Required: Data Z, counters 0, and a subsequent read of 0x00009 returns its old value.

Source files
------------

// File: rtl/sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg (package)
// Purpose  : Shared types and widths for the external 16-bit async SRAM pin
//            interface. The controller side and the responder side both use
//            the same widths, lane mask and state encoding.
// Contents : SRAM_AW, SRAM_DW, sram_lanes_t, sram_resp_state_t,
//            lanes_from_pins()
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  // Lane mask, 1 = lane enabled. Bit 1 covers Data[15:8], bit 0 Data[7:0].
  typedef logic [1:0] sram_lanes_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_HOLD = 2'd1,
    READ_WAIT  = 2'd2,
    READ_DRIVE = 2'd3
  } sram_resp_state_t;

  // UB/LB are active-low on the pins; the mask is active-high.
  function automatic sram_lanes_t lanes_from_pins(input logic ub, input logic lb);
    return {~ub, ~lb};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_if (interface)
// Purpose  : Control and address pins of the async SRAM. The bidirectional
//            Data bus is kept as a plain inout net so its tristate resolves
//            at the pin, not inside the interface.
// Ports    : CE, OE, WE, UB, LB (active-low), ADDR[SRAM_AW-1:0]
// Modports : master - controller side (drives pins)
//            slave  - responder side (samples pins)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_if;
  import sram_pkg::*;

  logic               CE;
  logic               OE;
  logic               WE;
  logic               UB;
  logic               LB;
  logic [SRAM_AW-1:0] ADDR;

  modport master (output CE, OE, WE, UB, LB, ADDR);
  modport slave  (input  CE, OE, WE, UB, LB, ADDR);

endinterface
`default_nettype wire

// File: rtl/sram_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : sram_resp_mem
// Purpose  : 2^MEM_AW x 16 synchronous RAM with per-byte write enables, one
//            write port and one registered read port on the same clock.
//            A read of the word being written on the same edge returns the
//            new data on the written lanes (write-first).
// Ports    : clock_100          clock
//            wr_en/wr_lanes     write strobe and byte-lane mask
//            wr_addr/wr_data    write address / data
//            rd_en/rd_addr      read strobe / address
//            rd_data            registered read data (holds when rd_en low)
// Revision : 1.0 - initial release
// ============================================================================
module sram_resp_mem
  import sram_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  wire logic               clock_100,
  input  wire logic               wr_en,
  input  wire sram_lanes_t        wr_lanes,
  input  wire logic [MEM_AW-1:0]  wr_addr,
  input  wire logic [SRAM_DW-1:0] wr_data,
  input  wire logic               rd_en,
  input  wire logic [MEM_AW-1:0]  rd_addr,
  output logic      [SRAM_DW-1:0] rd_data
);

  localparam int DEPTH = 1 << MEM_AW;

  // Contents are intentionally not reset.
  logic [SRAM_DW-1:0] r_mem [DEPTH];
  logic [SRAM_DW-1:0] r_rd_data;
  logic               w_hit;

  assign w_hit = wr_en && (wr_addr == rd_addr);

  always_ff @(posedge clock_100) begin
    if (wr_en && wr_lanes[1]) r_mem[wr_addr][15:8] <= wr_data[15:8];
    if (wr_en && wr_lanes[0]) r_mem[wr_addr][7:0]  <= wr_data[7:0];
    if (rd_en) begin
      r_rd_data[15:8] <= (w_hit && wr_lanes[1]) ? wr_data[15:8] : r_mem[rd_addr][15:8];
      r_rd_data[7:0]  <= (w_hit && wr_lanes[0]) ? wr_data[7:0]  : r_mem[rd_addr][7:0];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Purpose  : Stands in for an external 16-bit async SRAM chip. Samples the
//            pins every clock edge, commits writes when the write cycle ends
//            and drives read data back after READ_LATENCY edges.
// Params   : MEM_AW       backing-store address width (ADDR aliases above it)
//            READ_LATENCY edges from sampled read address to Data, 1..4
// Ports    : clock_100    system clock
//            reset_n      asynchronous active-low reset
//            bus          sram_if.slave (CE, OE, WE, UB, LB, ADDR)
//            Data         bidirectional 16-bit data bus
//            wr_count     committed writes (wraps)
//            rd_count     completed read drives (wraps)
//            violation    sticky protocol-violation flag
// Macro    : SRAM_RESPONDER_TIMING_CHECK_EN - when defined, the violation
//            checks are built; otherwise violation is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder
  import sram_pkg::*;
#(
  parameter int MEM_AW       = 12,
  parameter int READ_LATENCY = 1
) (
  input  wire logic               clock_100,
  input  wire logic               reset_n,
  sram_if.slave                   bus,
  inout  wire       [SRAM_DW-1:0] Data,
  output logic      [15:0]        wr_count,
  output logic      [15:0]        rd_count,
  output logic                    violation
);

  localparam logic [1:0] c_lat_reload = 2'(READ_LATENCY - 1);

  sram_resp_state_t   r_state;
  logic [SRAM_AW-1:0] r_cap_addr;
  logic [SRAM_DW-1:0] r_cap_data;
  sram_lanes_t        r_cap_lanes;
  logic [SRAM_AW-1:0] r_rd_addr;
  logic [1:0]         r_lat_cnt;
  sram_lanes_t        r_drive_lanes;
  logic [15:0]        r_wr_count;
  logic [15:0]        r_rd_count;

  logic               w_wr_req;
  logic               w_rd_req;
  sram_lanes_t        w_pin_lanes;
  logic               w_wr_addr_moved;
  logic               w_rd_addr_moved;
  logic               w_decode;   // evaluate the sampled pins as IDLE would
  logic               w_start;    // begin a read at the sampled address
  logic               w_fetch;    // register the memory word this edge
  logic               w_commit;   // close out the pending write capture
  logic               w_capture;  // take address/data/lanes from the pins
  logic               w_mem_we;
  logic [SRAM_DW-1:0] w_rd_data;

  assign w_wr_req        = ~bus.CE & ~bus.WE;
  assign w_rd_req        = ~bus.CE &  bus.WE & ~bus.OE;
  assign w_pin_lanes     = lanes_from_pins(bus.UB, bus.LB);
  assign w_wr_addr_moved = (bus.ADDR != r_cap_addr);
  assign w_rd_addr_moved = (bus.ADDR != r_rd_addr);
  // A capture with both lanes off writes nothing and is not counted.
  assign w_mem_we        = w_commit & (|r_cap_lanes);

  always_comb begin
    w_decode  = 1'b0;
    w_start   = 1'b0;
    w_fetch   = 1'b0;
    w_commit  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: w_decode = 1'b1;
      WRITE_HOLD: begin
        if (!w_wr_req) begin
          w_commit = 1'b1;
          w_decode = 1'b1;
        end else begin
          // Same address: recapture, last value wins. New address: the
          // old word is committed and the new one captured.
          w_commit  = w_wr_addr_moved;
          w_capture = 1'b1;
        end
      end
      READ_WAIT: begin
        if (!w_rd_req)             w_decode = 1'b1;
        else if (w_rd_addr_moved)  w_start  = 1'b1;
        else if (r_lat_cnt == 2'd1) w_fetch = 1'b1;
      end
      READ_DRIVE: begin
        if (!w_rd_req)            w_decode = 1'b1;
        else if (w_rd_addr_moved) w_start  = 1'b1;
      end
      default: w_decode = 1'b1;
    endcase
    if (w_decode && w_wr_req) w_capture = 1'b1;
    if (w_decode && w_rd_req) w_start   = 1'b1;
    // With a latency of one the word is fetched on the very edge that
    // samples the address, so Data is valid in the following cycle.
    if (w_start && (c_lat_reload == 2'd0)) w_fetch = 1'b1;
  end

  always_ff @(posedge clock_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cap_addr    <= '0;
      r_cap_data    <= '0;
      r_cap_lanes   <= '0;
      r_rd_addr     <= '0;
      r_lat_cnt     <= '0;
      r_drive_lanes <= '0;
      r_wr_count    <= '0;
      r_rd_count    <= '0;
    end else begin
      if (w_mem_we) r_wr_count <= r_wr_count + 16'd1;
      if (w_fetch)  r_rd_count <= r_rd_count + 16'd1;

      if (w_capture) begin
        r_cap_addr  <= bus.ADDR;
        r_cap_data  <= Data;
        r_cap_lanes <= w_pin_lanes;
      end

      case (r_state)
        READ_WAIT:  if (w_rd_req) r_lat_cnt <= r_lat_cnt - 2'd1;
        READ_DRIVE: if (w_rd_req) r_drive_lanes <= w_pin_lanes;
        default: ;
      endcase

      // Later assignments take priority: decode, then read start, then fetch.
      if (w_decode) begin
        r_drive_lanes <= '0;
        r_state       <= w_wr_req ? WRITE_HOLD : IDLE;
      end
      if (w_start) begin
        r_rd_addr     <= bus.ADDR;
        r_lat_cnt     <= c_lat_reload;
        r_drive_lanes <= '0;
        r_state       <= READ_WAIT;
      end
      if (w_fetch) begin
        r_drive_lanes <= w_pin_lanes;
        r_state       <= READ_DRIVE;
      end
    end
  end

  sram_resp_mem #(
    .MEM_AW (MEM_AW)
  ) u_mem (
    .clock_100 (clock_100),
    .wr_en     (w_mem_we),
    .wr_lanes  (r_cap_lanes),
    .wr_addr   (r_cap_addr[MEM_AW-1:0]),
    .wr_data   (r_cap_data),
    .rd_en     (w_fetch),
    .rd_addr   (bus.ADDR[MEM_AW-1:0]),
    .rd_data   (w_rd_data)
  );

  // Output enables come straight from registers, never from the pins.
  assign Data[15:8] = r_drive_lanes[1] ? w_rd_data[15:8] : 8'hzz;
  assign Data[7:0]  = r_drive_lanes[0] ? w_rd_data[7:0]  : 8'hzz;

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;

`ifdef SRAM_RESPONDER_TIMING_CHECK_EN
  logic r_violation;
  logic w_viol_set;

  // Address moving under an active write, or the bus being driven while the
  // pins request a write (OE and WE both low).
  assign w_viol_set = ((r_state == WRITE_HOLD) && w_wr_req && w_wr_addr_moved) ||
                      ((|r_drive_lanes) && !bus.OE && !bus.WE);

  always_ff @(posedge clock_100 or negedge reset_n) begin
    if (!reset_n)        r_violation <= 1'b0;
    else if (w_viol_set) r_violation <= 1'b1;
  end

  assign violation = r_violation;
`else
  assign violation = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Purpose  : Directed self-checking bench for sram_responder. Two responders
//            share one set of pins: dut1 with READ_LATENCY=1 and dut3 with
//            READ_LATENCY=3. Each has its own Data net with pull-ups, so an
//            undriven lane reads back as 1s.
// Macro    : SRAM_RESPONDER_TIMING_CHECK_EN selects the expected violation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_responder;
  import sram_pkg::*;

`ifdef SRAM_RESPONDER_TIMING_CHECK_EN
  localparam logic VIOL_EXP = 1'b1;
`else
  localparam logic VIOL_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_if bus ();

  wire  [SRAM_DW-1:0] data1;
  wire  [SRAM_DW-1:0] data3;
  logic [SRAM_DW-1:0] tb_dout;
  logic               tb_doe;

  assign data1 = tb_doe ? tb_dout : 16'hzzzz;
  assign data3 = tb_doe ? tb_dout : 16'hzzzz;

  for (genvar i = 0; i < SRAM_DW; i++) begin : g_pull
    pullup (data1[i]);
    pullup (data3[i]);
  end

  logic [15:0] wr1, rd1, wr3, rd3;
  logic        viol1, viol3;

  sram_responder #(.MEM_AW(12), .READ_LATENCY(1)) dut1 (
    .clock_100 (clk),
    .reset_n   (rst_n),
    .bus       (bus.slave),
    .Data      (data1),
    .wr_count  (wr1),
    .rd_count  (rd1),
    .violation (viol1)
  );

  sram_responder #(.MEM_AW(12), .READ_LATENCY(3)) dut3 (
    .clock_100 (clk),
    .reset_n   (rst_n),
    .bus       (bus.slave),
    .Data      (data3),
    .wr_count  (wr3),
    .rd_count  (rd3),
    .violation (viol3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pins_idle();
    bus.CE = 1'b1;
    bus.WE = 1'b1;
    bus.OE = 1'b1;
    bus.UB = 1'b0;
    bus.LB = 1'b0;
    tb_doe = 1'b0;
  endtask

  task automatic pins_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
    bus.CE   = 1'b0;
    bus.WE   = 1'b0;
    bus.OE   = 1'b1;
    bus.UB   = ub;
    bus.LB   = lb;
    bus.ADDR = a;
    tb_dout  = d;
    tb_doe   = 1'b1;
  endtask

  task automatic pins_read(input logic [19:0] a, input logic ub, input logic lb);
    tb_doe   = 1'b0;
    bus.CE   = 1'b0;
    bus.WE   = 1'b1;
    bus.OE   = 1'b0;
    bus.UB   = ub;
    bus.LB   = lb;
    bus.ADDR = a;
  endtask

  // Full write: pins held for n edges, then one idle edge to commit.
  task automatic write_word(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb, input int n);
    pins_write(a, d, ub, lb);
    repeat (n) step();
    pins_idle();
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    tb_dout  = 16'h0000;
    bus.ADDR = 20'h0;
    pins_idle();
    step();
    step();

    // Reset state
    check("reset_wr_count", 32'(wr1), 32'h0);
    check("reset_rd_count", 32'(rd1), 32'h0);
    check("reset_violation", 32'(viol1), 32'h0);
    check("reset_data_z", 32'(data1), 32'hFFFF);
    rst_n = 1'b1;
    step();

    // Write 0xBEEF to 0x00012 for two cycles, then read it back
    write_word(20'h00012, 16'hBEEF, 1'b0, 1'b0, 2);
    check("wb_wr_count", 32'(wr1), 32'd1);
    pins_read(20'h00012, 1'b0, 1'b0);
    step();
    check("wb_data", 32'(data1), 32'hBEEF);
    check("wb_rd_count", 32'(rd1), 32'd1);
    pins_idle();
    step();
    check("wb_release_z", 32'(data1), 32'hFFFF);

    // Byte lanes: 0xFFFF, then 0x1234 on the lower lane only, then a
    // write with both lanes off that must change nothing
    write_word(20'h00005, 16'hFFFF, 1'b0, 1'b0, 1);
    write_word(20'h00005, 16'h1234, 1'b1, 1'b0, 1);
    write_word(20'h00005, 16'h0000, 1'b1, 1'b1, 1);
    check("lanes_wr_count", 32'(wr1), 32'd3);
    pins_read(20'h00005, 1'b0, 1'b0);
    step();
    check("lanes_data", 32'(data1), 32'hFF34);
    check("lanes_rd_count", 32'(rd1), 32'd2);
    bus.LB = 1'b1;
    step();
    check("lanes_lb_off_z", 32'(data1), 32'hFFFF);
    check("lanes_rd_count_hold", 32'(rd1), 32'd2);
    pins_idle();
    step();

    // Forwarding: commit and read sample the same address on one edge
    write_word(20'h00100, 16'h5A5A, 1'b0, 1'b0, 1);
    pins_write(20'h00100, 16'hA5A5, 1'b0, 1'b0);
    step();
    pins_read(20'h00100, 1'b0, 1'b0);
    step();
    check("fwd_data", 32'(data1), 32'hA5A5);
    check("fwd_wr_count", 32'(wr1), 32'd5);
    check("fwd_rd_count", 32'(rd1), 32'd3);
    pins_idle();
    step();

    // Address change while WE stays low
    pins_write(20'h00001, 16'h1111, 1'b0, 1'b0);
    step();
    pins_write(20'h00002, 16'h2222, 1'b0, 1'b0);
    step();
    pins_idle();
    step();
    check("addrchg_wr_count", 32'(wr1), 32'd7);
    check("addrchg_violation", 32'(viol1), 32'(VIOL_EXP));
    pins_read(20'h00001, 1'b0, 1'b0);
    step();
    check("addrchg_rd1", 32'(data1), 32'h1111);
    bus.ADDR = 20'h00002;
    step();
    check("addrchg_rd2", 32'(data1), 32'h2222);
    check("addrchg_rd_count", 32'(rd1), 32'd5);
    pins_idle();
    step();

    // Latency 3 and aliasing: 0x01003 maps onto 0x003 with MEM_AW=12
    write_word(20'h00003, 16'h7777, 1'b0, 1'b0, 1);
    pins_read(20'h01003, 1'b0, 1'b0);
    step();
    check("alias_lat1_data", 32'(data1), 32'h7777);
    check("lat3_z_cycle1", 32'(data3), 32'hFFFF);
    step();
    check("lat3_z_cycle2", 32'(data3), 32'hFFFF);
    step();
    check("lat3_data", 32'(data3), 32'h7777);
    check("lat3_rd_count", 32'(rd3), 32'd1);
    check("lat3_wr_count", 32'(wr3), 32'd8);
    pins_idle();
    step();

    // Reset asserted in the middle of a write hold
    write_word(20'h00009, 16'h1357, 1'b0, 1'b0, 1);
    pins_write(20'h00009, 16'hDEAD, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    pins_idle();
    step();
    check("rstw_wr_count", 32'(wr1), 32'h0);
    check("rstw_rd_count", 32'(rd1), 32'h0);
    check("rstw_violation", 32'(viol1), 32'h0);
    check("rstw_data_z", 32'(data1), 32'hFFFF);
    rst_n = 1'b1;
    step();
    pins_read(20'h00009, 1'b0, 1'b0);
    step();
    check("rstw_old_value", 32'(data1), 32'h1357);
    check("rstw_no_commit", 32'(wr1), 32'h0);

    // Contention: WE dropped while the read word is on the bus
    bus.WE = 1'b0;
    step();
    check("contend_violation", 32'(viol1), 32'(VIOL_EXP));
    check("contend_data_z", 32'(data1), 32'hFFFF);
    check("contend_lat3_no_viol", 32'(viol3), 32'h0);
    pins_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
